// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: writeback arbiter and busy scoreboard for the 32x32 register file.
// Two writeback requesters (A = ALU, B = LSU) share one registered write port.
// Decode is stalled on RAW/WAW hazards against pending destination registers.
module regfile_wb_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid_i,
  input  logic [4:0]  issue_rs1_i,
  input  logic [4:0]  issue_rs2_i,
  input  logic [4:0]  issue_rd_i,
  input  logic        issue_rd_wr_i,
  output logic        issue_stall_o,
  input  logic        a_valid_i,
  input  logic [4:0]  a_rd_i,
  input  logic [31:0] a_data_i,
  output logic        a_ready_o,
  input  logic        b_valid_i,
  input  logic [4:0]  b_rd_i,
  input  logic [31:0] b_data_i,
  output logic        b_ready_o,
  output logic [4:0]  wr_port_o,
  output logic [31:0] wr_data_o,
  output logic        ctrl_reg_wr_en_o,
  output logic [31:0] busy_o,
  output logic        err_o
);

  // Round-robin preference: which requester wins when both are valid.
  typedef enum logic {
    PREF_A = 1'b0,
    PREF_B = 1'b1
  } pref_e;

  pref_e       r_pref;
  pref_e       w_pref_nxt;

  logic [31:0] r_busy;
  logic [31:0] w_busy_nxt;
  logic        r_err;
  logic [4:0]  r_wr_port;
  logic [31:0] r_wr_data;
  logic        r_wr_en;

  logic        w_rs1_hot;
  logic        w_rs2_hot;
  logic        w_rd_hot;
  logic        w_stall;
  logic        w_issue_accept;
  logic        w_issue_set;

  logic        w_gnt_a;
  logic        w_gnt_b;
  logic        w_gnt;
  logic [4:0]  w_gnt_rd;
  logic [31:0] w_gnt_data;
  logic        w_gnt_nonzero;
  logic        w_gnt_err;

  // Hazard detection: a register is hot when non-zero and pending a write.
  always_comb begin
    w_rs1_hot      = (issue_rs1_i != '0) & r_busy[issue_rs1_i];
    w_rs2_hot      = (issue_rs2_i != '0) & r_busy[issue_rs2_i];
    w_rd_hot       = (issue_rd_i  != '0) & r_busy[issue_rd_i];
    w_stall        = issue_valid_i & (w_rs1_hot | w_rs2_hot | (issue_rd_wr_i & w_rd_hot));
    w_issue_accept = issue_valid_i & ~w_stall;
    w_issue_set    = w_issue_accept & issue_rd_wr_i & (issue_rd_i != '0);
  end

  // Writeback arbitration: single requester always wins, ties go to the preferred side.
  always_comb begin
    w_gnt_a    = 1'b0;
    w_gnt_b    = 1'b0;
    w_pref_nxt = r_pref;
    if (a_valid_i && b_valid_i) begin
      if (r_pref == PREF_A) begin
        w_gnt_a = 1'b1;
      end else begin
        w_gnt_b = 1'b1;
      end
    end else if (a_valid_i) begin
      w_gnt_a = 1'b1;
    end else if (b_valid_i) begin
      w_gnt_b = 1'b1;
    end
    // The side just served loses the next tie; no grant leaves preference unchanged.
    if (w_gnt_a) begin
      w_pref_nxt = PREF_B;
    end else if (w_gnt_b) begin
      w_pref_nxt = PREF_A;
    end
  end

  // Granted payload selection and writeback-to-idle-register error detection.
  always_comb begin
    w_gnt         = w_gnt_a | w_gnt_b;
    w_gnt_rd      = w_gnt_b ? b_rd_i   : a_rd_i;
    w_gnt_data    = w_gnt_b ? b_data_i : a_data_i;
    w_gnt_nonzero = (w_gnt_rd != '0);
    w_gnt_err     = w_gnt & w_gnt_nonzero & ~r_busy[w_gnt_rd];
  end

  // Scoreboard next state: retire the committing write, then mark the new issue (set wins).
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_wr_en) begin
      w_busy_nxt[r_wr_port] = 1'b0;
    end
    if (w_issue_set) begin
      w_busy_nxt[issue_rd_i] = 1'b1;
    end
  end

  // State registers: scoreboard, error flag, arbiter preference and registered write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy    <= '0;
      r_err     <= 1'b0;
      r_pref    <= PREF_A;
      r_wr_port <= '0;
      r_wr_data <= '0;
      r_wr_en   <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_pref <= w_pref_nxt;
      if (w_gnt_err) begin
        r_err <= 1'b1;
      end
      // An rd=0 writeback is handshaken but never reaches the register file.
      if (w_gnt) begin
        r_wr_port <= w_gnt_rd;
        r_wr_data <= w_gnt_data;
        r_wr_en   <= w_gnt_nonzero;
      end else begin
        r_wr_en   <= 1'b0;
      end
    end
  end

  assign issue_stall_o    = w_stall;
  assign a_ready_o        = w_gnt_a;
  assign b_ready_o        = w_gnt_b;
  assign wr_port_o        = r_wr_port;
  assign wr_data_o        = r_wr_data;
  assign ctrl_reg_wr_en_o = r_wr_en;
  assign busy_o           = r_busy;
  assign err_o            = r_err;

endmodule
